// File: rtl/tx_pipe_arbiter.sv
// Message-granular round-robin arbiter sharing one byte-wide tx pipe between N_REQ requesters.
// Optional grant-revocation timeout: define TX_ARB_TIMEOUT_EN.
module tx_pipe_arbiter #(
  parameter int N_REQ          = 2,
  parameter int BYTE_W         = 8,
  parameter int TIMEOUT_CYCLES = 1_200_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*BYTE_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    push_back,
  output logic [BYTE_W-1:0]       data_in,
  input  logic                    full
`ifdef TX_ARB_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             xfer;
  logic             timeout;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // First valid requester strictly after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(rr_ptr_q) + k) % N_REQ;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == LOCKED && !rst) req_ready[owner_q] = !full;
  end

  assign push_back = (state_q == LOCKED) && req_valid[owner_q] && !full && !rst;
  assign data_in   = req_data[int'(owner_q)*BYTE_W +: BYTE_W];
  assign xfer      = push_back;
  assign grant     = grant_q;

`ifdef TX_ARB_TIMEOUT_EN
  // Only genuinely idle owner cycles count; a full-stalled pipe is not the owner's fault.
  assign timeout   = (state_q == LOCKED) && !xfer && !full &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;
`else
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = LOCKED;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
        end
      end
      LOCKED: begin
        if ((xfer && req_last[owner_q]) || timeout) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TX_ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q || timeout;
    if (state_q == IDLE || xfer) cnt_d = '0;
    else if (!full)              cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= IDX_W'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_tx_pipe_arbiter.sv
// Directed bench for tx_pipe_arbiter (2 requesters); timeout scenario built when TX_ARB_TIMEOUT_EN is defined.
module tb_tx_pipe_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        push_back;
  logic [7:0]  data_in;
  logic        full;
`ifdef TX_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  tx_pipe_arbiter #(.N_REQ(2), .BYTE_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .push_back(push_back), .data_in(data_in), .full(full)
`ifdef TX_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen 1 unit later, mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;

    // 1: "Hi\n" from req 0
    do_reset();
    settle();
    chk("rst_grant", grant, 2'b00);
    chk("rst_push", push_back, 1'b0);
    chk("rst_ready", req_ready, 2'b00);
    req_valid = 2'b01; req_data = 16'h0048; settle();
    chk("t1_idle_push", push_back, 1'b0);
    chk("t1_idle_grant", grant, 2'b00);
    tick(); settle();
    chk("t1_grant", grant, 2'b01);
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_push0", push_back, 1'b1);
    chk("t1_data0", data_in, 8'h48);
    tick(); req_data = 16'h0069; settle();
    chk("t1_push1", push_back, 1'b1);
    chk("t1_data1", data_in, 8'h69);
    tick(); req_data = 16'h000A; req_last = 2'b01; settle();
    chk("t1_push2", push_back, 1'b1);
    chk("t1_data2", data_in, 8'h0A);
    tick(); req_valid = '0; req_last = '0; settle();
    chk("t1_release", grant, 2'b00);
    chk("t1_nopush", push_back, 1'b0);

    // 2: simultaneous requests, round-robin
    do_reset();
    req_valid = 2'b11; req_data = 16'hB0A0; settle();
    tick(); settle();
    chk("t2_grant0", grant, 2'b01);
    chk("t2_dA0", data_in, 8'hA0);
    chk("t2_ready0", req_ready, 2'b01);
    tick(); req_data = 16'hB0A1; req_last = 2'b01; settle();
    chk("t2_dA1", data_in, 8'hA1);
    chk("t2_pA1", push_back, 1'b1);
    tick(); req_data = 16'hB0A2; req_last = 2'b00; settle();
    chk("t2_gap_grant", grant, 2'b00);
    chk("t2_gap_push", push_back, 1'b0);
    tick(); settle();
    chk("t2_grant1", grant, 2'b10);
    chk("t2_dB0", data_in, 8'hB0);
    chk("t2_ready1", req_ready, 2'b10);
    tick(); req_data = 16'hB1A2; req_last = 2'b10; settle();
    chk("t2_dB1", data_in, 8'hB1);
    tick(); req_valid = 2'b01; req_last = 2'b01; settle();
    chk("t2_gap2", grant, 2'b00);
    tick(); settle();
    chk("t2_grant0b", grant, 2'b01);
    chk("t2_dA2", data_in, 8'hA2);
    chk("t2_pA2", push_back, 1'b1);
    tick(); req_valid = '0; req_last = '0;

    // 3: full stall mid-message on req 1
    do_reset();
    req_valid = 2'b10; req_data = 16'hB000;
    tick(); settle();
    chk("t3_grant", grant, 2'b10);
    chk("t3_dB0", data_in, 8'hB0);
    tick(); req_data = 16'hB100; req_last = 2'b10; full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t3_stall_push", push_back, 1'b0);
      chk("t3_stall_ready", req_ready, 2'b00);
      chk("t3_stall_grant", grant, 2'b10);
      tick();
    end
    full = 1'b0; settle();
    chk("t3_resume_push", push_back, 1'b1);
    chk("t3_resume_data", data_in, 8'hB1);
    chk("t3_resume_ready", req_ready, 2'b10);
    tick(); req_valid = '0; req_last = '0; settle();
    chk("t3_release", grant, 2'b00);

    // 4: owner goes quiet, non-owner ignored
    do_reset();
    req_valid = 2'b01; req_data = 16'h00A0;
    tick(); settle();
    chk("t4_grant", grant, 2'b01);
    chk("t4_dA0", data_in, 8'hA0);
    tick(); req_valid = 2'b10; req_data = 16'hB0A1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("t4_hold_grant", grant, 2'b01);
      chk("t4_hold_push", push_back, 1'b0);
      chk("t4_hold_ready", req_ready, 2'b01);
      tick();
    end
    req_valid = 2'b11; req_last = 2'b01; settle();
    chk("t4_pA1", push_back, 1'b1);
    chk("t4_dA1", data_in, 8'hA1);
    tick(); req_valid = 2'b10; req_last = 2'b10; settle();
    chk("t4_gap", grant, 2'b00);
    tick(); settle();
    chk("t4_grant1", grant, 2'b10);
    chk("t4_dB0", data_in, 8'hB0);
    chk("t4_pB0", push_back, 1'b1);
    tick(); req_valid = '0; req_last = '0;

    // 5: reset mid-message
    do_reset();
    req_valid = 2'b10; req_data = 16'hC000;
    tick(); settle();
    chk("t5_grant", grant, 2'b10);
    chk("t5_dC0", data_in, 8'hC0);
    tick(); req_data = 16'hC100; settle();
    chk("t5_dC1", data_in, 8'hC1);
    tick(); req_data = 16'hC200; rst = 1'b1; settle();
    chk("t5_rst_push", push_back, 1'b0);
    chk("t5_rst_ready", req_ready, 2'b00);
    tick(); rst = 1'b0; req_valid = 2'b11; req_data = 16'hC2D0; settle();
    chk("t5_after_grant", grant, 2'b00);
    chk("t5_after_push", push_back, 1'b0);
    tick(); settle();
    chk("t5_regrant", grant, 2'b01);
    chk("t5_dD0", data_in, 8'hD0);
    req_last = 2'b01;
    tick(); req_valid = '0; req_last = '0;

`ifdef TX_ARB_TIMEOUT_EN
    // 6: idle owner revoked after 16 stall-free cycles
    do_reset();
    settle();
    chk("t6_err_rst", timeout_err, 1'b0);
    req_valid = 2'b01; req_data = 16'hE000;
    tick(); req_valid = 2'b10; req_data = 16'hE100;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("t6_hold_grant", grant, 2'b01);
      chk("t6_hold_err", timeout_err, 1'b0);
      tick();
    end
    settle();
    chk("t6_revoked", grant, 2'b00);
    chk("t6_err_set", timeout_err, 1'b1);
    tick(); settle();
    chk("t6_grant1", grant, 2'b10);
    chk("t6_dE1", data_in, 8'hE1);
    req_last = 2'b10;
    tick(); req_valid = '0; req_last = '0;
    tick(); tick(); settle();
    chk("t6_err_sticky", timeout_err, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0; settle();
    chk("t6_err_clr", timeout_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
